// File: rtl/comp_pkg.sv
// Shared helpers and state encoding for the comparator-sharing arbiter.
package comp_pkg;

  function automatic int id_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } rsp_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the lowest requesting index at or above ptr, wrapping to 0.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  input  logic            en,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  gnt_idx
);

  logic found;

  // First pass covers ptr..NREQ-1, second pass picks up the wrap-around 0..ptr-1.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (en && !found && req[i] && (IDW'(i) >= ptr)) begin
        found   = 1'b1;
        gnt[i]  = 1'b1;
        gnt_idx = IDW'(i);
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (en && !found && req[i]) begin
        found   = 1'b1;
        gnt[i]  = 1'b1;
        gnt_idx = IDW'(i);
      end
    end
  end

endmodule

// File: rtl/comp_share_arb.sv
// Shares one unsigned magnitude comparator among NREQ round-robin requesters.
// Define COMP_ARB_PIPE_EN to insert an operand register stage ahead of the comparator (latency 2).
module comp_share_arb
  import comp_pkg::*;
#(
  parameter int DATAWIDTH = 8,
  parameter int NREQ      = 4,
  parameter int IDW       = id_width(NREQ)
) (
  input  logic                      Clk,
  input  logic                      Rst,
  input  logic [NREQ-1:0]           req_valid,
  input  logic [NREQ*DATAWIDTH-1:0] req_a,
  input  logic [NREQ*DATAWIDTH-1:0] req_b,
  output logic [NREQ-1:0]           req_ready,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [IDW-1:0]            rsp_id,
  output logic                      rsp_gt,
  output logic                      rsp_lt,
  output logic                      rsp_eq
);

  logic [DATAWIDTH-1:0] opa [NREQ];
  logic [DATAWIDTH-1:0] opb [NREQ];

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign opa[gi] = req_a[gi*DATAWIDTH +: DATAWIDTH];
    assign opb[gi] = req_b[gi*DATAWIDTH +: DATAWIDTH];
  end

  rsp_state_e           state, state_next;
  logic [IDW-1:0]       ptr;
  logic [NREQ-1:0]      gnt;
  logic [IDW-1:0]       gnt_idx;
  logic                 can_accept;
  logic                 accept;
  logic                 load_out;
  logic [DATAWIDTH-1:0] cmp_a, cmp_b;
  logic [IDW-1:0]       cmp_id;

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .req     (req_valid),
    .ptr     (ptr),
    .en      (can_accept),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign accept    = |gnt;
  // Flops are held in reset anyway; only the visible handshake needs masking.
  assign req_ready = gnt & {NREQ{Rst}};

`ifdef COMP_ARB_PIPE_EN
  logic                 stage_valid;
  logic [DATAWIDTH-1:0] stage_a, stage_b;
  logic [IDW-1:0]       stage_id;
  logic                 advance;

  assign advance    = (state == ST_EMPTY) | rsp_ready;
  assign can_accept = ~stage_valid | advance;
  assign load_out   = stage_valid & advance;
  assign cmp_a      = stage_a;
  assign cmp_b      = stage_b;
  assign cmp_id     = stage_id;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      stage_valid <= 1'b0;
      stage_a     <= '0;
      stage_b     <= '0;
      stage_id    <= '0;
    end else if (accept) begin
      stage_valid <= 1'b1;
      stage_a     <= opa[gnt_idx];
      stage_b     <= opb[gnt_idx];
      stage_id    <= gnt_idx;
    end else if (advance) begin
      stage_valid <= 1'b0;
    end
  end
`else
  assign can_accept = (state == ST_EMPTY) | rsp_ready;
  assign load_out   = accept;
  assign cmp_a      = opa[gnt_idx];
  assign cmp_b      = opb[gnt_idx];
  assign cmp_id     = gnt_idx;
`endif

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      ptr <= '0;
    end else if (accept) begin
      ptr <= (gnt_idx == IDW'(NREQ-1)) ? '0 : gnt_idx + 1'b1;
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      rsp_id <= '0;
      rsp_gt <= 1'b0;
      rsp_lt <= 1'b0;
      rsp_eq <= 1'b0;
    end else if (load_out) begin
      rsp_id <= cmp_id;
      rsp_gt <= (cmp_a > cmp_b);
      rsp_lt <= (cmp_a < cmp_b);
      rsp_eq <= (cmp_a == cmp_b);
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) state <= ST_EMPTY;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    rsp_valid  = 1'b0;
    case (state)
      ST_EMPTY: begin
        if (load_out) state_next = ST_FULL;
      end
      ST_FULL: begin
        rsp_valid = 1'b1;
        if (rsp_ready && !load_out) state_next = ST_EMPTY;
      end
      default: state_next = ST_EMPTY;
    endcase
  end

endmodule
